// File: rtl/uart_ram_if.sv
// rtl/uart_ram_if.sv - UART receiver / block RAM / transmitter bus bundle for uart_ram_ctrl
// Optional UART_RAM_CTRL_ERR_CNT_EN adds the err_cnt status output.

interface uart_ram_if #(
    parameter int ADDR_W = 10
);
    logic              rx_data_valid;
    logic [7:0]        rx_data;
    logic              rx_block_timeout;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              busy;
    logic              err;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
    logic [7:0]        err_cnt;

    modport master (
        input  rx_data_valid, rx_data, rx_block_timeout, ram_rdata, tx_ready,
        output ram_we, ram_re, ram_addr, ram_wdata, tx_valid, tx_data, busy, err, err_cnt
    );
    modport slave (
        output rx_data_valid, rx_data, rx_block_timeout, ram_rdata, tx_ready,
        input  ram_we, ram_re, ram_addr, ram_wdata, tx_valid, tx_data, busy, err, err_cnt
    );
`else
    modport master (
        input  rx_data_valid, rx_data, rx_block_timeout, ram_rdata, tx_ready,
        output ram_we, ram_re, ram_addr, ram_wdata, tx_valid, tx_data, busy, err
    );
    modport slave (
        output rx_data_valid, rx_data, rx_block_timeout, ram_rdata, tx_ready,
        input  ram_we, ram_re, ram_addr, ram_wdata, tx_valid, tx_data, busy, err
    );
`endif
endinterface

// File: rtl/uart_ram_ctrl.sv
// rtl/uart_ram_ctrl.sv - UART byte-frame command sequencer driving the on-chip block RAM
// Optional UART_RAM_CTRL_ERR_CNT_EN: saturating err_cnt, returned by a read of address 0xFFFF.

module uart_ram_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    uart_ram_if.master bus
);
    localparam logic [7:0]        CMD_WR   = 8'h57;
    localparam logic [7:0]        CMD_RD   = 8'h52;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WR_DATA, S_RD_LEN,
        S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              is_rd_q, is_rd_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [8:0]        count_q, count_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              err_q, err_d;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              stat_q, stat_d;
`endif

    logic rx_valid;
    logic rx_to;
    assign rx_valid = bus.rx_data_valid;
    assign rx_to    = bus.rx_block_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_rd_q    <= 1'b0;
            hi_q       <= 8'h00;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            count_q    <= 9'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            err_q      <= 1'b0;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
            err_cnt_q  <= 8'h00;
            stat_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_rd_q    <= is_rd_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            count_q    <= count_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
            err_cnt_q  <= err_cnt_d;
            stat_q     <= stat_d;
`endif
        end
    end

    // A byte arriving with the timeout is handled first; the timeout then
    // overrides the next state according to the state the byte arrived in.
    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        count_d    = count_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
        stat_d     = stat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
                        is_rd_d = (bus.rx_data == CMD_RD);
                        state_d = S_ADDR_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_ADDR_HI: begin
                if (rx_valid) begin
                    hi_d    = bus.rx_data;
                    state_d = S_ADDR_LO;
                end
                if (rx_to) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ADDR_LO: begin
                if (rx_valid) begin
                    addr_d  = ADDR_W'({hi_q, bus.rx_data});
                    state_d = is_rd_q ? S_RD_LEN : S_WR_DATA;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
                    stat_d  = is_rd_q && ({hi_q, bus.rx_data} == 16'hFFFF);
                    if (stat_d) addr_d = '0;
`endif
                end
                if (rx_to) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (rx_valid) begin
                    we_d      = 1'b1;
                    wr_addr_d = addr_q;
                    wdata_d   = bus.rx_data;
                    addr_d    = addr_q + ADDR_ONE;
                end
                if (rx_to) state_d = S_IDLE;
            end
            S_RD_LEN: begin
                if (rx_valid) begin
                    count_d = {1'b0, bus.rx_data} + 9'd1;
                    state_d = S_RD_REQ;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
                    // Status read: first byte is the counter, no RAM access.
                    if (stat_q) begin
                        tx_data_d  = err_cnt_q;
                        tx_valid_d = 1'b1;
                        state_d    = S_RD_SEND;
                    end
`endif
                end
                if (rx_to) begin
                    err_d      = 1'b1;
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_RD_REQ: begin
                err_d   = rx_valid;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                err_d      = rx_valid;
                tx_data_d  = bus.ram_rdata;
                tx_valid_d = 1'b1;
                state_d    = S_RD_SEND;
            end
            S_RD_SEND: begin
                err_d = rx_valid;
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    count_d    = count_q - 9'd1;
                    addr_d     = addr_q + ADDR_ONE;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
                    if (stat_q) begin
                        stat_d = 1'b0;
                        addr_d = addr_q;
                    end
`endif
                    state_d = (count_q == 9'd1) ? S_IDLE : S_RD_REQ;
                end
            end
            S_DRAIN: begin
                if (rx_to) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef UART_RAM_CTRL_ERR_CNT_EN
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
    end

    assign bus.ram_re    = (state_q == S_RD_REQ);
    assign bus.ram_addr  = (state_q == S_RD_REQ) ? addr_q : wr_addr_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err       = err_q;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
    assign bus.err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// tb/tb_uart_ram_ctrl.sv - scoreboard bench for uart_ram_ctrl against a frame-level reference model

module tb_uart_ram_ctrl;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_ram_if #(.ADDR_W(AW)) bus ();
    uart_ram_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_seen = 0, err_exp = 0, err_since_rst = 0, re_seen = 0;
    int ready_mode = 0, hold_cnt = 0;
    logic [7:0]    ram     [DEPTH];
    logic [7:0]    ref_mem [DEPTH];
    logic [7:0]    rd_q;
    logic [AW+7:0] exp_wr [$];
    logic [7:0]    exp_tx [$];
    logic [7:0]    pay    [$];
    logic          prev_stall = 1'b0;
    logic [7:0]    prev_data  = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event unexpected or not seen within bound", name);
    endtask

    // Behavioural block RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) rd_q <= ram[bus.ram_addr];
    end
    assign bus.ram_rdata = rd_q;

    // Monitor: pops the scoreboard whenever the DUT presents a write or a tx handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else check("ram_write", int'({bus.ram_addr, bus.ram_wdata}), int'(exp_wr.pop_front()));
            end
            if (bus.ram_re) re_seen++;
            if (bus.err) err_seen++;
            if (prev_stall) check("tx_hold", int'({bus.tx_valid, bus.tx_data}), int'({1'b1, prev_data}));
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) fail_now("unexpected_tx");
                else check("tx_byte", int'(bus.tx_data), int'(exp_tx.pop_front()));
            end
        end
        prev_stall = !rst && bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
    end

    // tx_ready driver: 0 always ready, 1 random, 2 stall 20 cycles per byte.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) bus.tx_ready = 1'b1;
            else if (ready_mode == 1) bus.tx_ready = 1'($urandom_range(0, 1));
            else begin
                if (bus.tx_valid && !bus.tx_ready) hold_cnt++;
                else hold_cnt = 0;
                bus.tx_ready = (hold_cnt >= 20);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b, input bit with_to);
        bus.rx_data          = b;
        bus.rx_data_valid    = 1'b1;
        bus.rx_block_timeout = with_to;
        tick();
        bus.rx_data_valid    = 1'b0;
        bus.rx_block_timeout = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic timeout();
        bus.rx_block_timeout = 1'b1;
        tick();
        bus.rx_block_timeout = 1'b0;
        tick();
    endtask

    task automatic note_err();
        err_exp++;
        err_since_rst++;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) fail_now(name);
        tick();
    endtask

    // Write frame; payload from pay[] if filled, else len random bytes.
    task automatic do_write(input logic [15:0] a, input int len, input bit merge_to);
        int n = (pay.size() > 0) ? pay.size() : len;
        send(8'h57, 1'b0);
        send(a[15:8], 1'b0);
        send(a[7:0], 1'b0);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b = (pay.size() > 0) ? pay.pop_front() : 8'($urandom);
            int idx = (int'(a) + i) % DEPTH;
            exp_wr.push_back({AW'(idx), b});
            ref_mem[idx] = b;
            send(b, merge_to && (i == n - 1));
        end
        if (!merge_to) timeout();
        check("busy_after_write", int'(bus.busy), 0);
        wait_idle("write_drain");
    endtask

    task automatic do_read(input logic [15:0] a, input int len_b, input bit to_after, input bit stray);
        int re0    = re_seen;
        int exp_re = len_b + 1;
`ifdef UART_RAM_CTRL_ERR_CNT_EN
        if (a == 16'hFFFF) begin
            exp_tx.push_back(8'((err_since_rst > 255) ? 255 : err_since_rst));
            for (int i = 0; i < len_b; i++) exp_tx.push_back(ref_mem[i % DEPTH]);
            exp_re = len_b;
        end else
`endif
        for (int i = 0; i <= len_b; i++) exp_tx.push_back(ref_mem[(int'(a) + i) % DEPTH]);
        send(8'h52, 1'b0);
        send(a[15:8], 1'b0);
        send(a[7:0], 1'b0);
        send(8'(len_b), 1'b0);
        if (to_after) timeout();
        if (stray) begin
            int n = 0;
            while (!bus.tx_valid && n < 200) begin tick(); n++; end
            if (n >= 200) fail_now("stray_wait");
            send(8'h33, 1'b0);
            note_err();
        end
        wait_idle("read_drain");
        check("ram_re_count", re_seen - re0, exp_re);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data_valid    = 1'b0;
        bus.rx_data          = 8'h00;
        bus.rx_block_timeout = 1'b0;
        rd_q = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", int'(bus.ram_we), 0);
        check("rst_ram_re", int'(bus.ram_re), 0);
        check("rst_ram_addr", int'(bus.ram_addr), 0);
        check("rst_ram_wdata", int'(bus.ram_wdata), 0);
        check("rst_tx_valid", int'(bus.tx_valid), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
`ifdef UART_RAM_CTRL_ERR_CNT_EN
        check("rst_err_cnt", int'(bus.err_cnt), 0);
`endif
        rst = 1'b0;
        tick();

        pay = '{8'hAA, 8'hBB};
        do_write(16'h0010, 0, 1'b0);
        ready_mode = 0;
        do_read(16'h0010, 1, 1'b1, 1'b0);

        pay = '{8'h11, 8'h22};
        do_write(16'h03FF, 0, 1'b0);
        do_read(16'h03FF, 1, 1'b0, 1'b0);

        send(8'h41, 1'b0);
        note_err();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        timeout();
        check("busy_after_drain", int'(bus.busy), 0);
        wait_idle("drain");

        send(8'h57, 1'b0);
        send(8'h00, 1'b0);
        timeout();
        note_err();
        check("busy_after_addr_timeout", int'(bus.busy), 0);

        ready_mode = 2;
        do_read(16'h0010, 2, 1'b0, 1'b1);

        ready_mode = 0;
        do_write(16'h2C20, 3, 1'b1);
        do_read(16'h0020, 2, 1'b0, 1'b0);

        for (int it = 0; it < 14; it++) begin
            ready_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1)
                do_write(16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
            else
                do_read({8'($urandom_range(0, 254)), 8'($urandom)}, $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), 1'b0);
        end
        check("err_pulses", err_seen, err_exp);

        ready_mode = 2;
        send(8'h52, 1'b0);
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h05, 1'b0);
        begin
            int n = 0;
            while (!bus.tx_valid && n < 200) begin tick(); n++; end
            if (n >= 200) fail_now("reset_read_wait");
        end
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_tx_valid", int'(bus.tx_valid), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
`ifdef UART_RAM_CTRL_ERR_CNT_EN
        check("rst_mid_err_cnt", int'(bus.err_cnt), 0);
`endif
        rst = 1'b0;
        err_since_rst = 0;
        exp_tx.delete();
        ready_mode = 0;
        tick();
        do_read(16'h03FF, 1, 1'b0, 1'b0);

`ifdef UART_RAM_CTRL_ERR_CNT_EN
        send(8'h00, 1'b0);
        note_err();
        timeout();
        send(8'h57, 1'b0);
        timeout();
        note_err();
        check("err_cnt_small", int'(bus.err_cnt), 2);
        do_read(16'hFFFF, 2, 1'b0, 1'b0);
        for (int i = 0; i < 258; i++) begin
            send(8'h00, 1'b0);
            note_err();
            timeout();
        end
        check("err_cnt_saturated", int'(bus.err_cnt), 255);
        do_read(16'hFFFF, 0, 1'b0, 1'b0);
`endif
        check("err_pulses_final", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
